dac_audio_sched: RTL and testbench

- Sample-rate scheduler and source arbiter in front of the PWM DAC output stage.
- Accepts audio samples from two requesters over valid/ready handshakes: src0 is demodulated receive audio, src1 is local/sidetone.
- Once per sample period it selects one source, applies a click-free gain ramp on source switch and mute, and presents a signed 32-bit sample to the DAC's data_in.

---
 rtl/dac_audio_sched_pkg.sv | 16 +
 rtl/dac_audio_sched_if.sv | 11 +
 rtl/dac_audio_sched_src_buf.sv | 40 ++++
 rtl/dac_audio_sched.sv | 163 ++++++++++++++++
 tb/tb_dac_audio_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_audio_sched_pkg.sv
// Shared audio definitions for the DAC sample scheduler: fade states and gain scaling constants.
package dac_audio_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_MUTED    = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_e;

  localparam int                GAIN_W             = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY         = GAIN_W'(256);
  localparam int                GAIN_SHIFT         = 8;
  localparam int                DEFAULT_SAMPLE_DIV = 1000;

endpackage

// File: rtl/dac_audio_sched_if.sv
// Valid/ready sample channel from an audio requester into the scheduler.
interface dac_audio_sched_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dac_audio_sched_src_buf.sv
// One-entry holding register for an audio source; emptied on every sample tick
// so the requester never stalls, with a same-edge load taking priority over the clear.
module audio_src_buf #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  dac_audio_sched_if.slave   src,
  output logic               full,
  output logic [DATA_W-1:0]  data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  assign src.ready = ~full_q;
  assign full      = full_q;
  assign data      = data_q;

  // Accept a sample when empty; a tick drains the entry unless a new one lands on that edge.
  always_comb begin
    load   = src.valid & ~full_q;
    full_d = load | (full_q & ~tick);
    data_d = load ? src.data : data_q;
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dac_audio_sched.sv
// Sample-rate scheduler and source arbiter feeding the PWM DAC: picks src0 or src1 once per
// sample period and ramps the gain through zero on source switches and mute to avoid clicks.
module dac_audio_sched
  import dac_audio_sched_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int RAMP_STEP  = 16,
  parameter int DATA_W     = 32
) (
  input  logic               clk_in,
  input  logic               RST,
  dac_audio_sched_if.slave   s0,
  dac_audio_sched_if.slave   s1,
  input  logic               sel_req,
  input  logic               mute,
  output logic [DATA_W-1:0]  data_out,
  output logic               sample_tick,
  output logic               cur_sel,
  output logic               underrun
);

  localparam int                CNT_W  = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [GAIN_W:0]   STEP_W  = (GAIN_W + 1)'(RAMP_STEP);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  state_e                   state_q, state_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic [GAIN_W-1:0]        gain_cap_q, gain_cap_d;
  logic                     cur_sel_q, cur_sel_d;
  logic signed [DATA_W-1:0] smp_q, smp_d;
  logic                     pend_q, pend_d;
  logic                     underrun_q, underrun_d;
  logic                     sample_tick_q, sample_tick_d;
  logic [DATA_W-1:0]        data_out_q, data_out_d;

  logic                     tick;
  logic                     s0_full, s1_full;
  logic [DATA_W-1:0]        s0_buf, s1_buf;
  logic                     sel_full;
  logic [DATA_W-1:0]        sel_data;
  logic [GAIN_W:0]          gain_up;
  logic [GAIN_W-1:0]        gain_up_sat;
  logic [GAIN_W-1:0]        gain_dn;
  logic signed [DATA_W+GAIN_W:0] prod;

  assign tick = (cnt_q == CNT_MAX);

  audio_src_buf #(.DATA_W(DATA_W)) u_buf0 (
    .clk (clk_in),
    .rst (RST),
    .tick(tick),
    .src (s0),
    .full(s0_full),
    .data(s0_buf)
  );

  audio_src_buf #(.DATA_W(DATA_W)) u_buf1 (
    .clk (clk_in),
    .rst (RST),
    .tick(tick),
    .src (s1),
    .full(s1_full),
    .data(s1_buf)
  );

  // Gain ramp arithmetic (saturating at zero and unity) and the output scaling product.
  always_comb begin
    sel_full    = cur_sel_q ? s1_full : s0_full;
    sel_data    = cur_sel_q ? s1_buf  : s0_buf;
    gain_up     = {1'b0, gain_q} + STEP_W;
    gain_up_sat = (gain_up >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_up[GAIN_W-1:0];
    gain_dn     = ({1'b0, gain_q} > STEP_W) ? GAIN_W'({1'b0, gain_q} - STEP_W) : '0;
    prod        = smp_q * $signed({1'b0, gain_cap_q});
  end

  // Next-state logic: tick counter, capture stage, fade state machine and output stage.
  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    state_d       = state_q;
    gain_d        = gain_q;
    gain_cap_d    = gain_cap_q;
    cur_sel_d     = cur_sel_q;
    smp_d         = smp_q;
    pend_d        = tick;
    underrun_d    = 1'b0;
    sample_tick_d = pend_q;
    data_out_d    = data_out_q;

    if (tick) begin
      smp_d      = sel_full ? $signed(sel_data) : smp_q;
      underrun_d = ~sel_full;
      gain_cap_d = gain_q;
      case (state_q)
        ST_RUN: begin
          if (mute || (sel_req != cur_sel_q)) state_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          gain_d = gain_dn;
          if (gain_dn == '0) begin
            if (mute) begin
              state_d = ST_MUTED;
            end else begin
              cur_sel_d = sel_req;
              state_d   = ST_FADE_IN;
            end
          end
        end
        ST_MUTED: begin
          gain_d = '0;
          if (!mute) begin
            cur_sel_d = sel_req;
            state_d   = ST_FADE_IN;
          end
        end
        ST_FADE_IN: begin
          if (mute || (sel_req != cur_sel_q)) begin
            state_d = ST_FADE_OUT;
          end else begin
            gain_d = gain_up_sat;
            if (gain_up_sat == GAIN_UNITY) state_d = ST_RUN;
          end
        end
        default: state_d = ST_FADE_IN;
      endcase
    end

    if (pend_q) data_out_d = DATA_W'(prod >>> GAIN_SHIFT);
  end

  // All scheduler state; reset lands in a fade-in from zero gain on src0.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      cnt_q         <= '0;
      state_q       <= ST_FADE_IN;
      gain_q        <= '0;
      gain_cap_q    <= '0;
      cur_sel_q     <= 1'b0;
      smp_q         <= '0;
      pend_q        <= 1'b0;
      underrun_q    <= 1'b0;
      sample_tick_q <= 1'b0;
      data_out_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      gain_q        <= gain_d;
      gain_cap_q    <= gain_cap_d;
      cur_sel_q     <= cur_sel_d;
      smp_q         <= smp_d;
      pend_q        <= pend_d;
      underrun_q    <= underrun_d;
      sample_tick_q <= sample_tick_d;
      data_out_q    <= data_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign sample_tick = sample_tick_q;
  assign cur_sel     = cur_sel_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dac_audio_sched.sv
// Directed bench for dac_audio_sched with SAMPLE_DIV=4 and RAMP_STEP=64.
module tb_dac_audio_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_req;
  logic        mute;
  logic [31:0] data_out;
  logic        sample_tick;
  logic        cur_sel;
  logic        underrun;

  int checks   = 0;
  int errors   = 0;
  int last_gap = 0;
  int underrun_cnt = 0;
  int s0_xfers = 0;
  int s1_xfers = 0;

  dac_audio_sched_if #(.DATA_W(32)) s0_if ();
  dac_audio_sched_if #(.DATA_W(32)) s1_if ();

  dac_audio_sched #(
    .SAMPLE_DIV(4),
    .RAMP_STEP (64),
    .DATA_W    (32)
  ) dut (
    .clk_in     (clk),
    .RST        (rst),
    .s0         (s0_if),
    .s1         (s1_if),
    .sel_req    (sel_req),
    .mute       (mute),
    .data_out   (data_out),
    .sample_tick(sample_tick),
    .cur_sel    (cur_sel),
    .underrun   (underrun)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Count handshakes on each source, sampled on the edge the transfer happens.
  always @(posedge clk) begin
    if (s0_if.valid && s0_if.ready) s0_xfers <= s0_xfers + 1;
    if (s1_if.valid && s1_if.ready) s1_xfers <= s1_xfers + 1;
  end

  // Count underrun pulses between clock edges.
  always @(negedge clk) begin
    if (underrun) underrun_cnt <= underrun_cnt + 1;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sample(input string tag, input logic [31:0] exp);
    int gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!sample_tick && gap < 20);
    last_gap = gap;
    check_output({tag, "_tick"}, 32'(sample_tick), 32'd1);
    check_output(tag, data_out, exp);
  endtask

  // Directed test sequence.
  initial begin
    int u0;
    int x0;
    rst = 1'b1;
    sel_req = 1'b0;
    mute = 1'b0;
    s0_if.data = '0;
    s0_if.valid = 1'b0;
    s1_if.data = '0;
    s1_if.valid = 1'b0;
    repeat (3) @(negedge clk);

    check_output("rst_data_out", data_out, 32'd0);
    check_output("rst_sample_tick", 32'(sample_tick), 32'd0);
    check_output("rst_underrun", 32'(underrun), 32'd0);
    check_output("rst_cur_sel", 32'(cur_sel), 32'd0);
    check_output("rst_s0_ready", 32'(s0_if.ready), 32'd1);
    check_output("rst_s1_ready", 32'(s1_if.ready), 32'd1);

    // Ramp up from reset on src0 streaming 1000.
    s0_if.data = 32'd1000;
    s0_if.valid = 1'b1;
    s1_if.data = 32'd8000;
    s1_if.valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_sample("ramp0", 32'd0);
    expect_sample("ramp1", 32'd250);
    check_output("ramp_gap1", 32'(last_gap), 32'd4);
    expect_sample("ramp2", 32'd500);
    check_output("ramp_gap2", 32'(last_gap), 32'd4);
    expect_sample("ramp3", 32'd750);
    check_output("ramp_gap3", 32'(last_gap), 32'd4);
    expect_sample("ramp4", 32'd1000);
    check_output("ramp_gap4", 32'(last_gap), 32'd4);
    check_output("ramp_no_underrun", 32'(underrun_cnt), 32'd0);

    // Switch from src0 (-4000) to src1 (8000) through zero gain.
    s0_if.data = 32'(-4000);
    expect_sample("sw_flush", 32'd1000);
    expect_sample("sw_run", 32'(-4000));
    sel_req = 1'b1;
    expect_sample("sw0", 32'(-4000));
    expect_sample("sw1", 32'(-4000));
    expect_sample("sw2", 32'(-3000));
    expect_sample("sw3", 32'(-2000));
    check_output("sw_cur_sel_before", 32'(cur_sel), 32'd0);
    expect_sample("sw4", 32'(-1000));
    expect_sample("sw5", 32'd0);
    check_output("sw_cur_sel_after", 32'(cur_sel), 32'd1);
    expect_sample("sw6", 32'd2000);
    expect_sample("sw7", 32'd4000);
    expect_sample("sw8", 32'd6000);
    expect_sample("sw9", 32'd8000);

    // Switch back to src0 carrying 0x40000000.
    s0_if.data = 32'h4000_0000;
    sel_req = 1'b0;
    expect_sample("back0", 32'd8000);
    expect_sample("back1", 32'd8000);
    expect_sample("back2", 32'd6000);
    expect_sample("back3", 32'd4000);
    expect_sample("back4", 32'd2000);
    expect_sample("back5", 32'd0);
    check_output("back_cur_sel", 32'(cur_sel), 32'd0);
    expect_sample("back6", 32'h1000_0000);
    expect_sample("back7", 32'h2000_0000);
    expect_sample("back8", 32'h3000_0000);
    expect_sample("back9", 32'h4000_0000);

    // Mute fades to zero and holds; src0 keeps being drained.
    mute = 1'b1;
    expect_sample("mute0", 32'h4000_0000);
    expect_sample("mute1", 32'h4000_0000);
    expect_sample("mute2", 32'h3000_0000);
    expect_sample("mute3", 32'h2000_0000);
    expect_sample("mute4", 32'h1000_0000);
    expect_sample("mute5", 32'd0);
    x0 = s0_xfers;
    expect_sample("mute6", 32'd0);
    expect_sample("mute7", 32'd0);
    check_output("mute_s0_recycle", 32'(s0_xfers - x0), 32'd2);
    mute = 1'b0;
    expect_sample("unmute0", 32'd0);
    expect_sample("unmute1", 32'd0);
    expect_sample("unmute2", 32'h1000_0000);
    expect_sample("unmute3", 32'h2000_0000);
    expect_sample("unmute4", 32'h3000_0000);
    expect_sample("unmute5", 32'h4000_0000);

    // Starve src0 for one full period: one underrun, last sample repeated.
    u0 = underrun_cnt;
    x0 = s1_xfers;
    s0_if.data = 32'h1234_5678;
    expect_sample("ur_flush", 32'h4000_0000);
    s0_if.valid = 1'b0;
    expect_sample("ur_new", 32'h1234_5678);
    check_output("ur_none_yet", 32'(underrun_cnt - u0), 32'd0);
    expect_sample("ur_repeat", 32'h1234_5678);
    check_output("ur_pulse", 32'(underrun_cnt - u0), 32'd1);
    s0_if.data = 32'h0000_1000;
    s0_if.valid = 1'b1;
    expect_sample("ur_resume", 32'h0000_1000);
    check_output("ur_single", 32'(underrun_cnt - u0), 32'd1);
    check_output("ur_s1_drained", 32'(s1_xfers - x0), 32'd4);

    // Brief sel_req glitch seen on one tick still forces a full fade, returning to src0.
    s0_if.data = 32'd256;
    expect_sample("gl_flush", 32'h0000_1000);
    expect_sample("gl_run", 32'd256);
    sel_req = 1'b1;
    expect_sample("gl0", 32'd256);
    sel_req = 1'b0;
    expect_sample("gl1", 32'd256);
    expect_sample("gl2", 32'd192);
    expect_sample("gl3", 32'd128);
    expect_sample("gl4", 32'd64);
    expect_sample("gl5", 32'd0);
    check_output("gl_cur_sel_mid", 32'(cur_sel), 32'd0);
    expect_sample("gl6", 32'd64);
    expect_sample("gl7", 32'd128);
    expect_sample("gl8", 32'd192);
    expect_sample("gl9", 32'd256);
    check_output("gl_cur_sel_end", 32'(cur_sel), 32'd0);

    // Reset asserted mid fade-out at gain 128.
    mute = 1'b1;
    expect_sample("rf0", 32'd256);
    expect_sample("rf1", 32'd256);
    expect_sample("rf2", 32'd192);
    check_output("rf_s0_busy", 32'(s0_if.ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("rf_data_out", data_out, 32'd0);
    check_output("rf_cur_sel", 32'(cur_sel), 32'd0);
    check_output("rf_s0_ready", 32'(s0_if.ready), 32'd1);
    check_output("rf_s1_ready", 32'(s1_if.ready), 32'd1);
    check_output("rf_sample_tick", 32'(sample_tick), 32'd0);
    @(negedge clk);
    mute = 1'b0;
    s0_if.data = 32'h7FFF_FFFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_sample("ext0", 32'd0);
    expect_sample("ext1", 32'h1FFF_FFFF);
    expect_sample("ext2", 32'h3FFF_FFFF);
    expect_sample("ext3", 32'h5FFF_FFFF);
    expect_sample("ext4", 32'h7FFF_FFFF);
    s0_if.data = 32'h8000_0000;
    expect_sample("ext5", 32'h7FFF_FFFF);
    expect_sample("ext6", 32'h8000_0000);
    check_output("ext_cur_sel", 32'(cur_sel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
